fmap_writeback: RTL and testbench
=================================

FMAP_WRITEBACK -- requirements
Module: fmap_writeback

Interface
REQ-001 Parameter DATA_WIDTH, default 8, pixel width.
REQ-002 Parameter ADDR_WIDTH, default 11, feature-map RAM address width.
REQ-003 Parameter BANK_OFFSET, default 1024, base address of bank 1; bank 0 base is 0.
REQ-004 clk  input  1  clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle pulse: begin one output frame.
REQ-007 mode  input  3  frame size select, sampled on start: 0->28, 1->14, 2->10, 3->5, 4..7 invalid.
REQ-008 in_valid  input  1  result pixel valid.
REQ-009 in_data  input  DATA_WIDTH  result pixel, two's complement, raster order.
REQ-010 in_ready  output  1  block accepts a pixel this cycle.
REQ-011 ram_write_en  output  1  RAM write strobe, registered.
REQ-012 ram_write_addr  output  ADDR_WIDTH  RAM write address, registered.
REQ-013 ram_write_data  output  DATA_WIDTH  RAM write data, registered.
REQ-014 busy  output  1  frame in progress.
REQ-015 done  output  1  one-cycle pulse on final write.
REQ-016 err  output  1  sticky: start seen with invalid mode; cleared by next valid start.
REQ-017 bank_sel  output  1  bank being written or last written.

Function
REQ-018 FSM states IDLE, WRITE, DONE; encoding free.
REQ-019 IDLE: start with mode 0..3 -> latch size S, clear row/col/addr counters, set err=0, go WRITE; start with mode 4..7 -> set err=1, stay IDLE.
REQ-020 in_ready SHALL be 1 in WRITE only, 0 in IDLE and DONE.
REQ-021 Transfer = in_valid && in_ready; one pixel per transfer; in_valid low in WRITE inserts bubbles without changing counters.
REQ-022 Transfer in cycle N -> ram_write_en=1 in cycle N+1 with addr = base(bank_sel) + row*S + col and the (processed) pixel; ram_write_en=0 in every other cycle.
REQ-023 Address formed with an incrementing linear counter (no multiplier); col wraps S-1->0 and increments row.
REQ-024 Transfer at row=S-1, col=S-1 -> go DONE; DONE lasts exactly one cycle, done=1 in it (coincident with final ram_write_en), then IDLE.
REQ-025 On DONE->IDLE, bank_sel SHALL toggle so the next frame targets the other bank.
REQ-026 busy=1 in WRITE and DONE, 0 in IDLE.
REQ-027 start while busy SHALL be ignored (no state, counter, mode or err change).
REQ-028 Pixels offered in IDLE/DONE are not accepted and never written.
REQ-029 Address arithmetic ADDR_WIDTH bits, no overflow for S<=28 and BANK_OFFSET=1024.

Reset
REQ-030 rst_n low asynchronously forces IDLE, counters 0, ram_write_en=0, ram_write_addr=0, ram_write_data=0, in_ready=0, busy=0, done=0, err=0, bank_sel=0.
REQ-031 Reset mid-frame aborts the frame; no further writes occur; partial data in RAM is not cleaned up.

Configuration
REQ-032 Macro FMAP_WB_RELU_EN defined: pixel with MSB=1 SHALL be written as 0, others unchanged.
REQ-033 Macro FMAP_WB_RELU_EN undefined: in_data written unmodified; no extra latency in either case.

Verification
REQ-034 Reset, start mode=3, 25 back-to-back pixels 1..25 -> writes addr 0..24 data 1..25, each one cycle after its transfer; done with addr 24; bank_sel=1 afterwards.
REQ-035 Second frame mode=3 after REQ-034 -> addresses 1024..1048; bank_sel returns 0 after done.
REQ-036 mode=0 frame, in_valid toggling 1/0 -> exactly 784 writes, addr 0..783 contiguous, no writes in bubble-following cycles, done once.
REQ-037 start mode=5 -> err=1, in_ready=0, no writes; then start mode=2 -> err=0, 100 writes.
REQ-038 start pulse in middle of mode=1 frame -> ignored, frame completes at 196 writes; rst_n low after 50 pixels -> ram_write_en=0 immediately, IDLE, bank_sel=0.
REQ-039 in_data=8'hF0 with FMAP_WB_RELU_EN -> 8'h00 written; without -> 8'hF0 written; 8'h7F written unchanged in both.

Source files
------------

// File: rtl/fmap_writeback.sv
// fmap_writeback: streams one square feature-map frame of result pixels into a
// double-buffered feature-map RAM. Frames alternate between bank 0 (base 0) and
// bank 1 (base BANK_OFFSET), so a consumer can read one bank while the other fills.
// The frame side length S (28, 14, 10 or 5) is selected by mode when start is seen.
// Optional build macro FMAP_WB_RELU_EN: negative pixels are written as zero (ReLU).
// Without the macro, pixels are written unmodified. Both builds have the same latency.

module fmap_writeback #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 11,
    parameter int BANK_OFFSET = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            mode,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  ram_write_en,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  bank_sel
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state;
    logic [4:0]              size;     // frame side length S
    logic [4:0]              row;
    logic [4:0]              col;
    logic [ADDR_WIDTH-1:0]   lin;      // row*S + col, kept as a running count
    logic [ADDR_WIDTH-1:0]   base;
    logic [DATA_WIDTH-1:0]   pixel;
    logic                    transfer;

    assign transfer = in_valid && in_ready;

    // Select the bank base address and apply the optional activation to the pixel.
    always_comb begin
        // NOTE: every signal assigned here gets a value on every path first, so no latch is inferred.
        base  = bank_sel ? ADDR_WIDTH'(BANK_OFFSET) : '0;
        pixel = in_data;
`ifdef FMAP_WB_RELU_EN
        if (in_data[DATA_WIDTH-1]) begin
            pixel = '0;
        end
`endif
    end

    // Frame sequencer: state, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            size           <= 5'd0;
            row            <= 5'd0;
            col            <= 5'd0;
            lin            <= '0;
            in_ready       <= 1'b0;
            ram_write_en   <= 1'b0;
            ram_write_addr <= '0;
            ram_write_data <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            bank_sel       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from the
            // same pre-edge values, regardless of statement order in this block.
            ram_write_en <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!mode[2]) begin
                            case (mode[1:0])
                                2'd0:    size <= 5'd28;
                                2'd1:    size <= 5'd14;
                                2'd2:    size <= 5'd10;
                                default: size <= 5'd5;
                            endcase
                            row      <= 5'd0;
                            col      <= 5'd0;
                            lin      <= '0;
                            err      <= 1'b0;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            state    <= WRITE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    // Pixel written one cycle after it is accepted; bubbles leave counters alone.
                    if (transfer) begin
                        ram_write_en   <= 1'b1;
                        ram_write_addr <= base + lin;
                        ram_write_data <= pixel;
                        lin            <= lin + ADDR_WIDTH'(1);
                        if (col == size - 5'd1) begin
                            col <= 5'd0;
                            row <= row + 5'd1;
                            if (row == size - 5'd1) begin
                                in_ready <= 1'b0;
                                done     <= 1'b1;
                                state    <= DONE;
                            end
                        end else begin
                            col <= col + 5'd1;
                        end
                    end
                end
                DONE: begin
                    // Next frame goes to the other bank.
                    bank_sel <= ~bank_sel;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fmap_writeback.sv
// Self-checking bench for fmap_writeback: randomized frames against a
// behavioural model (pixel count vs S*S, bank flag, sticky error flag), compared
// every cycle, plus literal expectations on frame write counts and addresses.

module tb_fmap_writeback;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  mode;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        ram_write_en;
    logic [10:0] ram_write_addr;
    logic [7:0]  ram_write_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        bank_sel;

    fmap_writeback #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (11),
        .BANK_OFFSET(1024)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .mode          (mode),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .ram_write_en  (ram_write_en),
        .ram_write_addr(ram_write_addr),
        .ram_write_data(ram_write_data),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .bank_sel      (bank_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Behavioural model: frame in progress, accepting pixels, pixels taken, side length.
    logic m_busy, m_ready, m_err, m_bank;
    int   m_size, m_count;
    logic e_en, e_done;
    int   e_addr;
    logic [7:0] e_data;

    // Per-frame observations of the DUT write port.
    int n_wr, n_done, first_addr, last_addr;
    logic [7:0] wr_data [0:1023];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int size_of(input logic [2:0] md);
        case (md)
            3'd0:    return 28;
            3'd1:    return 14;
            3'd2:    return 10;
            default: return 5;
        endcase
    endfunction

    function automatic logic [7:0] relu(input logic [7:0] d);
`ifdef FMAP_WB_RELU_EN
        return d[7] ? 8'h00 : d;
`else
        return d;
`endif
    endfunction

    task automatic model_reset();
        m_busy = 0; m_ready = 0; m_err = 0; m_bank = 0;
        m_size = 0; m_count = 0; e_en = 0; e_done = 0; e_addr = 0; e_data = 0;
    endtask

    // One clock: drive inputs, predict the post-edge outputs, then compare.
    task automatic step(input logic s, input logic [2:0] md, input logic v, input logic [7:0] d);
        start = s; mode = md; in_valid = v; in_data = d;
        e_en = 0; e_done = 0;
        if (!m_busy) begin
            if (s) begin
                if (md < 3'd4) begin
                    m_size = size_of(md); m_count = 0; m_err = 0; m_busy = 1; m_ready = 1;
                end else begin
                    m_err = 1;
                end
            end
        end else if (m_ready) begin
            if (v) begin
                e_en   = 1;
                e_addr = (m_bank ? 1024 : 0) + m_count;
                e_data = relu(d);
                m_count++;
                if (m_count == m_size * m_size) begin
                    m_ready = 0;
                    e_done  = 1;
                end
            end
        end else begin
            m_busy = 0;
            m_bank = ~m_bank;
        end
        @(posedge clk);
        #1;
        check("in_ready", in_ready, m_ready);
        check("busy", busy, m_busy);
        check("err", err, m_err);
        check("bank_sel", bank_sel, m_bank);
        check("done", done, e_done);
        check("ram_write_en", ram_write_en, e_en);
        if (e_en) begin
            check("ram_write_addr", ram_write_addr, e_addr);
            check("ram_write_data", ram_write_data, e_data);
        end
        if (ram_write_en) begin
            if (n_wr == 0) first_addr = ram_write_addr;
            last_addr = ram_write_addr;
            if (n_wr < 1024) wr_data[n_wr] = ram_write_data;
            n_wr++;
        end
        if (done) n_done++;
        start = 0; in_valid = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"}, ram_write_en, 0);
        check({tag, "_addr"}, ram_write_addr, 0);
        check({tag, "_data"}, ram_write_data, 0);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_bank"}, bank_sel, 0);
    endtask

    // pattern 0: back-to-back data 1..; 1: valid toggling; 2: random with a stray start;
    // 3: back-to-back alternating F0/7F. abort_at>0 pulls rst_n after that many pixels.
    task automatic run_frame(input logic [2:0] md, input int pattern, input int abort_at);
        int cyc;
        logic v, s;
        logic [7:0] d;
        logic [2:0] smd;
        n_wr = 0; n_done = 0; first_addr = -1; last_addr = -1;
        step(1'b1, md, 1'b0, 8'h00);
        if (md >= 3'd4) return;
        cyc = 0;
        while (m_busy && cyc < 3000) begin
            if (abort_at > 0 && m_count == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("abort");
                model_reset();
                #3;
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
            s = 1'b0; smd = 3'($urandom_range(0, 7)); d = 8'($urandom);
            case (pattern)
                0:       begin v = 1'b1; d = 8'(m_count + 1); end
                1:       v = (cyc % 2 == 0);
                2:       begin v = ($urandom_range(0, 2) != 0); s = (cyc == 40); end
                default: begin v = 1'b1; d = (m_count % 2 == 1) ? 8'h7F : 8'hF0; end
            endcase
            step(s, smd, v, d);
            cyc++;
        end
        if (m_busy) check("frame_timeout", 1, 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'($urandom), 8'($urandom));
    endtask

    initial begin
        rst_n = 1'b0; start = 0; mode = 0; in_valid = 0; in_data = 0;
        model_reset();
        #1;
        check_reset_outputs("reset");
        #13;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Frame 1: S=5, pixels 1..25 into bank 0.
        run_frame(3'd3, 0, 0);
        check("f1_writes", n_wr, 25);
        check("f1_first", first_addr, 0);
        check("f1_last", last_addr, 24);
        check("f1_data0", wr_data[0], 8'd1);
        check("f1_data24", wr_data[24], 8'd25);
        check("f1_done", n_done, 1);
        check("f1_bank", bank_sel, 1);
        idle_cycles(2);

        // Frame 2: S=5 into bank 1.
        run_frame(3'd3, 0, 0);
        check("f2_first", first_addr, 1024);
        check("f2_last", last_addr, 1048);
        check("f2_bank", bank_sel, 0);

        // Frame 3: S=28 with bubbles every other cycle.
        run_frame(3'd0, 1, 0);
        check("f3_writes", n_wr, 784);
        check("f3_first", first_addr, 0);
        check("f3_last", last_addr, 783);
        check("f3_done", n_done, 1);
        idle_cycles(3);

        // Invalid mode, then a valid S=10 frame clears err.
        run_frame(3'd5, 0, 0);
        check("inv_err", err, 1);
        check("inv_ready", in_ready, 0);
        idle_cycles(3);
        check("inv_writes", n_wr, 0);
        run_frame(3'd2, 2, 0);
        check("f4_writes", n_wr, 100);
        check("f4_err", err, 0);
        check("f4_first", first_addr, 1024);
        check("f4_last", last_addr, 1123);

        // Activation check: F0 then 7F.
        run_frame(3'd3, 3, 0);
`ifdef FMAP_WB_RELU_EN
        check("relu_f0", wr_data[0], 8'h00);
`else
        check("relu_f0", wr_data[0], 8'hF0);
`endif
        check("relu_7f", wr_data[1], 8'h7F);

        // S=14 with a stray start mid-frame.
        run_frame(3'd1, 2, 0);
        check("f6_writes", n_wr, 196);
        check("f6_done", n_done, 1);
        idle_cycles(2);
        run_frame(3'd3, 2, 0);
        check("f7_bank", bank_sel, 1);

        // S=14 aborted by reset after 50 pixels.
        run_frame(3'd1, 2, 50);
        check("abort_writes", n_wr, 50);
        idle_cycles(3);
        run_frame(3'd3, 0, 0);
        check("f9_first", first_addr, 0);
        check("f9_last", last_addr, 24);
        check("f9_bank", bank_sel, 1);
        idle_cycles(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
